// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a byte FIFO with valid/ready input
//
// Purpose: buffers bytes from the upstream stage in a 2**FIFO_AW deep circular
// FIFO and serializes them LSB first as 8N1 frames at CLK_HZ/BAUD cycles per
// bit. Defining UART_TX_PARITY_EN compiles in an even-parity bit (8E1).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   data       in   byte from upstream
//   data_valid in   data is valid this cycle
//   data_ready out  FIFO can accept a byte
//   tx         out  registered serial line, idle high
//   busy       out  frame in progress or FIFO non-empty
//   fifo_level out  number of bytes stored in the FIFO
module uart_tx_fifo #(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(DIV);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [7:0]         mem_q [DEPTH];
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic       push, pop, has_data, bit_end;
  logic [7:0] head;

  assign data_ready = (level_q != LVL_FULL);
  assign push       = data_valid && data_ready;
  assign has_data   = (level_q != '0);
  assign bit_end    = (cnt_q == CNT_LAST);
  assign head       = mem_q[rptr_q];

  assign tx         = tx_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != S_IDLE) || has_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (has_data) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = par_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          // Chain straight into the next start bit so queued frames are contiguous.
          if (has_data) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      level_q <= level_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Storage needs no reset: only slots covered by fifo_level are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= data;
  end

endmodule
